// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// Resolves conditional and unconditional control transfers in EX from the ALU
// flags and funct3. A direct-mapped table of 2-bit saturating counters (BHT)
// supplies a taken/not-taken prediction for the instruction in IF.
//
// Optional feature macro: BPU_PERF_CNT_EN
//   defined   -> 32-bit branch / mispredict counters are instantiated
//   undefined -> o_br_count and o_mis_count are tied to zero
//
// Parameters
//   BHT_ENTRIES   number of counters (power of two, >= 2)
//   PC_W          program-counter width
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   i_fetch_pc         PC in IF            -> o_pred_taken (combinational)
//   i_ex_*             EX instruction info, target, fall-through, prediction
//   i_*_flag           Z/C/V/S from rs1 - rs2
//   o_take_branch      resolved outcome              (combinational)
//   o_mispredict       flush and redirect this cycle (combinational)
//   o_redirect_pc      PC to load on mispredict      (combinational)
//   o_br_count         branch/jump count             (registered)
//   o_mis_count        mispredict count              (registered)
module branch_predict_unit #(
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned PC_W        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] i_fetch_pc,
    output logic            o_pred_taken,
    input  logic            i_ex_valid,
    input  logic            i_ex_branch,
    input  logic            i_ex_uncond,
    input  logic [2:0]      i_ex_funct3,
    input  logic [PC_W-1:0] i_ex_pc,
    input  logic            i_ex_pred_taken,
    input  logic [PC_W-1:0] i_ex_target,
    input  logic [PC_W-1:0] i_ex_pc_plus4,
    input  logic            i_zero_flag,
    input  logic            i_carry_flag,
    input  logic            i_overflow_flag,
    input  logic            i_sign_flag,
    output logic            o_take_branch,
    output logic            o_mispredict,
    output logic [PC_W-1:0] o_redirect_pc,
    output logic [31:0]     o_br_count,
    output logic [31:0]     o_mis_count
);

    localparam int unsigned IDX_W = (BHT_ENTRIES < 2) ? 1 : $clog2(BHT_ENTRIES);

    logic [1:0]       r_bht [BHT_ENTRIES];
    logic [IDX_W-1:0] w_fetch_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic [1:0]       w_ex_cnt;
    logic             w_cond;
    logic             w_is_cond;
    logic             w_take;
    logic             w_mispredict;
    logic             w_bht_upd;
    logic [PC_W-1:0]  w_redirect_pc;
    logic             w_unused;

    // Word-aligned index, no tag: PCs that differ only above the index alias.
    assign w_fetch_idx = i_fetch_pc[IDX_W+1:2];
    assign w_ex_idx    = i_ex_pc[IDX_W+1:2];
    assign w_ex_cnt    = r_bht[w_ex_idx];

    // Upper bit of the counter is the prediction; no write bypass.
    assign o_pred_taken = r_bht[w_fetch_idx][1];

    // Branch condition from funct3 and the flags of rs1 - rs2.
    always_comb begin
        w_cond = 1'b0;
        case (i_ex_funct3)
            3'b000:  w_cond = i_zero_flag;
            3'b001:  w_cond = ~i_zero_flag;
            3'b100:  w_cond = i_sign_flag ^ i_overflow_flag;
            3'b101:  w_cond = ~(i_sign_flag ^ i_overflow_flag);
            3'b110:  w_cond = ~i_carry_flag;
            3'b111:  w_cond = i_carry_flag;
            default: w_cond = 1'b0;
        endcase
    end

    // Unconditional transfers win over the branch flag and always redirect.
    assign w_is_cond    = i_ex_branch & ~i_ex_uncond;
    assign w_take       = i_ex_valid & (i_ex_uncond | (i_ex_branch & w_cond));
    assign w_mispredict = i_ex_valid &
                          (i_ex_uncond | (w_is_cond & (w_take != i_ex_pred_taken)));
    assign w_bht_upd    = i_ex_valid & w_is_cond;

    // Fall-through unless a taken transfer has to be redirected.
    always_comb begin
        w_redirect_pc = i_ex_pc_plus4;
        if (w_mispredict && w_take) begin
            w_redirect_pc = i_ex_target;
        end
    end

    assign o_take_branch = w_take;
    assign o_mispredict  = w_mispredict;
    assign o_redirect_pc = w_redirect_pc;

    // Saturating counter update for resolved conditional branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_bht_upd) begin
            if (w_take && (w_ex_cnt != 2'b11)) begin
                r_bht[w_ex_idx] <= w_ex_cnt + 2'd1;
            end else if (!w_take && (w_ex_cnt != 2'b00)) begin
                r_bht[w_ex_idx] <= w_ex_cnt - 2'd1;
            end
        end
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0] r_br_count;
    logic [31:0] r_mis_count;

    // Free-running totals, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count  <= 32'd0;
            r_mis_count <= 32'd0;
        end else begin
            if (i_ex_valid && (i_ex_branch || i_ex_uncond)) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (w_mispredict) begin
                r_mis_count <= r_mis_count + 32'd1;
            end
        end
    end

    assign o_br_count  = r_br_count;
    assign o_mis_count = r_mis_count;
`else
    assign o_br_count  = 32'd0;
    assign o_mis_count = 32'd0;
`endif

    // PC bits outside the index field do not take part in the lookup.
    assign w_unused = ^{i_fetch_pc[PC_W-1:IDX_W+2], i_fetch_pc[1:0],
                        i_ex_pc[PC_W-1:IDX_W+2], i_ex_pc[1:0]};

endmodule
